// File: rtl/rs232_loader_pkg.sv
// Shared types and constants for the RS232 boot loader.
// Holds FSM state and block-field encodings plus device register map.
package rs232_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_POLL,
        S_RDB,
        S_DISP,
        S_MEMW,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        F_LEN,
        F_ADR,
        F_DATA,
        F_TERM
    } field_t;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;
    localparam int   RXBNE    = 0;

endpackage

// File: rtl/rs232_loader_asm.sv
// Little-endian byte-to-word assembler with a 2-bit byte count.
// Ports: clk, rst, clr, shift, din[7:0] -> word[31:0], cnt[1:0], word_valid.
module rs232_loader_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [1:0]  cnt,
    output logic        word_valid
);

    // New bytes enter at the top, so the first byte ends up in [7:0].
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {din, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end

    assign word_valid = shift && (cnt == 2'd3);

endmodule

// File: rtl/rs232_loader.sv
// Boot loader: polls the serial device, assembles words and writes blocks.
// Ports: start/busy/done/err/entry control, dev_* device bus, mem_* write port.
module rs232_loader
    import rs232_loader_pkg::*;
#(
    parameter logic baud_sel       = 1'b0,
    parameter int   timeout_cycles = 50_000_000,
    parameter int   addr_width     = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [addr_width-1:0] entry,
    output logic                  dev_stb,
    output logic                  dev_we,
    output logic                  dev_addr,
    output logic [7:0]            dev_wdata,
    input  logic [31:0]           dev_rdata,
    input  logic                  dev_ack,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack
);

    localparam int TW = $clog2(timeout_cycles);
    localparam logic [TW-1:0] TO_MAX = TW'(timeout_cycles - 1);

    state_t state, state_n;
    field_t field;

    logic                  gap;
    logic                  dev_ok;
    logic [addr_width-3:0] acnt;
    logic [addr_width-3:0] wcnt;
    logic [TW-1:0]         to_cnt;
    logic                  wait_blk;
    logic                  to_hit;
    logic [31:0]           word;
    logic [1:0]            cnt;
    logic                  word_valid;
    logic                  unused_rdata;

    assign unused_rdata = ^dev_rdata[31:8];

    rs232_loader_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == S_IDLE && start),
        .shift      (state == S_RDB && dev_ok),
        .din        (dev_rdata[7:0]),
        .word       (word),
        .cnt        (cnt),
        .word_valid (word_valid)
    );

    assign dev_ok   = dev_stb && dev_ack;
    // Between blocks the host may idle forever, so no timeout there.
    assign wait_blk = (field == F_LEN) && (cnt == 2'd0);
    assign to_hit   = !wait_blk && (to_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (start) state_n = S_CFG;
            S_CFG:  if (dev_ok) state_n = S_POLL;
            S_POLL: begin
                if (dev_ok && dev_rdata[RXBNE]) state_n = S_RDB;
                else if (to_hit)                state_n = S_ERR;
            end
            S_RDB: if (dev_ok) state_n = word_valid ? S_DISP : S_POLL;
            S_DISP: begin
                unique case (field)
                    F_LEN: begin
                        if (word != 32'd0 && word[1:0] != 2'd0)
                            state_n = S_ERR;
                        else
                            state_n = S_POLL;
                    end
                    F_DATA:  state_n = S_MEMW;
                    F_TERM:  state_n = S_DONE;
                    default: state_n = S_POLL;
                endcase
            end
            S_MEMW: if (mem_ack) state_n = S_POLL;
            S_DONE: state_n = S_IDLE;
            S_ERR:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        dev_stb   = 1'b0;
        dev_we    = 1'b0;
        dev_addr  = REG_DATA;
        dev_wdata = 8'd0;
        mem_we    = 1'b0;
        unique case (state)
            S_CFG: begin
                dev_stb   = !gap;
                dev_we    = 1'b1;
                dev_addr  = REG_CTRL;
                dev_wdata = {7'd0, baud_sel};
            end
            S_POLL: begin
                dev_stb  = !gap;
                dev_addr = REG_CTRL;
            end
            S_RDB:  dev_stb = !gap;
            S_MEMW: mem_we  = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr  = {acnt, 2'b00};
    assign mem_wdata = word;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            entry  <= '0;
            field  <= F_LEN;
            acnt   <= '0;
            wcnt   <= '0;
            to_cnt <= '0;
        end else begin
            // Forces one idle strobe cycle after every acknowledged access.
            gap <= dev_ok;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        err    <= 1'b0;
                        entry  <= '0;
                        field  <= F_LEN;
                        to_cnt <= '0;
                    end
                end
                S_POLL: begin
                    if (wait_blk) to_cnt <= '0;
                    else          to_cnt <= to_cnt + 1'b1;
                end
                S_RDB: if (dev_ok) to_cnt <= '0;
                S_DISP: begin
                    unique case (field)
                        F_LEN: begin
                            if (word == 32'd0) begin
                                field <= F_TERM;
                            end else begin
                                wcnt  <= word[addr_width-1:2];
                                field <= F_ADR;
                            end
                        end
                        F_ADR: begin
                            acnt  <= word[addr_width-1:2];
                            field <= F_DATA;
                        end
                        F_TERM:  entry <= word[addr_width-1:0];
                        default: ;
                    endcase
                end
                S_MEMW: begin
                    if (mem_ack) begin
                        acnt <= acnt + 1'b1;
                        wcnt <= wcnt - 1'b1;
                        if (wcnt == {{(addr_width-3){1'b0}}, 1'b1})
                            field <= F_LEN;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                S_ERR: begin
                    err  <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rs232_loader.md
Name: rs232_loader

Overview:
Bus initiator that drives the RS232 serial device's slave port to boot-load memory over the serial line. It polls the device status, reads received bytes, and assembles them little-endian into 32-bit words. It parses a block stream (length, address, data) and writes the data words to memory. It sits between the serial device and the memory write port and is active only while the system is held in boot mode.

Parameters:
baud_sel, 1'b0, control value written to device control register at start (0: 115200, 1: 9600)
timeout_cycles, 50_000_000, max clk cycles to wait for a byte once a block has started
addr_width, 24, memory byte-address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse: begin load
busy  out  1  high from start until done or err
done  out  1  sticky: terminator block received
err  out  1  sticky: protocol error or timeout
entry  out  addr_width  entry address from the terminator block
dev_stb  out  1  device strobe
dev_we  out  1  device write enable
dev_addr  out  1  0: data register, 1: control/status register
dev_wdata  out  8  device write data
dev_rdata  in  32  device read data
dev_ack  in  1  device acknowledge
mem_we  out  1  memory write strobe
mem_addr  out  addr_width  word-aligned byte address
mem_wdata  out  32  memory write data
mem_ack  in  1  memory write acknowledge

Behaviour:
- Reset: all outputs 0; FSM in IDLE. A reset mid-load aborts immediately; memory writes already acknowledged are not undone.
- Device transaction: assert dev_stb plus we/addr/wdata; hold until the cycle with dev_ack=1; sample dev_rdata in that cycle; deassert next cycle. No two consecutive strobe cycles on the same transaction.
- States:
  - IDLE: on start go to CFG. Clear done, err, entry; set busy.
  - CFG: write {7'b0, baud_sel} to control (addr=1, we=1), then go to POLL.
  - POLL: read status (addr=1, we=0). If dev_rdata[0] (Rx buffer not empty) go to RDB, else stay in POLL.
  - RDB: read data (addr=0). Shift byte into word register, bytes[7:0] first (little-endian). Increment the 2-bit byte count. On the 4th byte go to DISP, else go to POLL.
  - DISP, by field:
    - LEN: if len==0, field:=TERM. Else if len[1:0]!=0, go to ERR. Else load the word counter with len>>2 and set field:=ADR.
    - ADR: load the address counter; field:=DATA.
    - DATA: go to MEMW.
    - TERM: entry:=word[addr_width-1:0]; go to DONE.
    - Other than MEMW/DONE/ERR, DISP returns to POLL.
  - MEMW: hold mem_we with mem_addr and mem_wdata until mem_ack. Then address += 4 and word count -= 1. If the count reaches 0, field:=LEN. Return to POLL.
  - DONE: done=1, busy=0; return to IDLE.
  - ERR: err=1, busy=0; return to IDLE.
- Timeout: counter cleared on every received byte and while field==LEN with byte count 0 (waiting between blocks, unbounded). Otherwise it increments in POLL. Reaching timeout_cycles-1 goes to ERR. Width is $clog2(timeout_cycles).
- start while busy: ignored.
- Address wrap: the address counter wraps modulo 2^addr_width with no error. mem_addr[1:0] is always driven 0.
- len field is 32 bits; only len>>2 truncated to addr_width-2 bits is used.

Decomposition:
- Shared package: FSM state encoding, field encoding (LEN/ADR/DATA/TERM), device register offsets (DATA=0, CTRL=1), and the status bit index RXBNE=0.
- Natural sub-module: rs232_loader_asm, which holds the byte-to-word little-endian assembler and the byte count (shift, count, word_valid).

Test Plan:
- Basic load: stream len=8, addr=0x100, data 0x11223344 and 0xAABBCCDD, then len=0, addr=0x200. Expect writes to 0x100 and 0x104 with those values, done=1, entry=0x200, err=0.
- Byte order: bytes 44 33 22 11 form word 0x11223344. Status-bit-0 polling with 0..20 empty polls between bytes produces identical results.
- Bad length: len=6 gives err=1 after the 4th length byte, no mem_we, busy=0.
- Timeout: stop after 2 data bytes with timeout_cycles=100 gives err=1 within ~100 cycles of the last byte. Idle time between blocks causes no timeout.
- Reset mid-block: assert rst after the 1st of 2 data words. All outputs return to 0 the next cycle, and a fresh start completes a new load normally.
- Handshake stalls: delay mem_ack by 0 to 5 cycles. Each write occurs exactly once and dev_stb never overlaps mem_we.
